// File: rtl/axi_rd_sched_pkg.sv
// Shared types and helpers for the AXI read-side stream scheduler.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package axi_rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ADDR  = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  localparam logic [1:0] OKAY = 2'b00;

  // Ceiling log2 for sizing index/counter fields; returns at least 1 for v>1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot and encoded grant over N requesters.
// Latency: grant is combinational from req; pointer updates one cycle after advance.
// Backpressure: none; the grant is held until the caller strobes advance.
// Ports: clk, reset (async, active-low), req[N], advance, gnt[N] (one-hot), gnt_idx.
module rr_arbiter
  import axi_rd_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx
);

  logic [SW-1:0] last_q;
  logic [SW-1:0] cand;
  logic          found;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = SW'((int'(last_q) + i) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = '0;
    if (found) gnt[gnt_idx] = 1'b1;
  end

  // Reset to the highest index so the first search begins at requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= SW'(N - 1);
    end else if (advance && found) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/axi_rd_stream_sched.sv
// AXI read scheduler: round-robin fixed-length INCR bursts for NUM_STREAMS generators, R data tagged by stream.
// Latency: start -> ARVALID after 2 edges; one AR per 2 cycles max; R path is zero-latency passthrough.
// Backpressure: AR held until ARREADY; issue stalls at MAX_OUTST outstanding; RREADY mirrors out_ready.
// Optional: define AXI_RD_SCHED_CHECK_EN to build response/RLAST checking that drives a sticky err.
// Ports: clk, reset (async active-low), start/stream_en/base_addr/bursts config, busy/done status,
//        AR* and R* AXI read channels, out_* tagged data stream, err.
module axi_rd_stream_sched
  import axi_rd_sched_pkg::*;
#(
  parameter  int NUM_STREAMS = 4,
  parameter  int ADDR_W      = 32,
  parameter  int ID_W        = 4,
  parameter  int DATA_W      = 512,
  parameter  int BURST_LEN   = 15,
  parameter  int MAX_OUTST   = 8,
  localparam int SW          = clog2(NUM_STREAMS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_STREAMS-1:0]        stream_en,
  input  logic [NUM_STREAMS*ADDR_W-1:0] base_addr,
  input  logic [15:0]                   bursts,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             ARADDR,
  output logic [ID_W-1:0]               ARID,
  output logic [7:0]                    ARLEN,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  input  logic [ID_W-1:0]               RID,
  input  logic [DATA_W-1:0]             RDATA,
  input  logic [1:0]                    RRESP,
  input  logic                          RLAST,
  input  logic                          RVALID,
  output logic                          RREADY,
  output logic                          out_valid,
  output logic [SW-1:0]                 out_stream,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          err
);

  localparam int                OW          = clog2(MAX_OUTST + 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'((BURST_LEN + 1) * (DATA_W / 8));

  sched_state_t state_q, state_d;

  logic [ADDR_W-1:0]      base_q [NUM_STREAMS];
  logic [15:0]            rem_q  [NUM_STREAMS];
  logic [15:0]            iss_q  [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] rem_nz;
  logic [NUM_STREAMS-1:0] req;
  logic [NUM_STREAMS-1:0] arb_gnt;
  logic [SW-1:0]          arb_idx;
  logic [SW-1:0]          cur_q;
  logic [OW-1:0]          outst_q;
  logic                   outst_full;
  logic [ADDR_W-1:0]      araddr_q;
  logic [ID_W-1:0]        arid_q;
  logic                   arvalid_q;
  logic                   done_q;
  logic                   ar_hs;
  logic                   rlast_hs;
  logic                   cfg_load;
  logic                   grant;
  logic                   done_set;

  assign ar_hs      = arvalid_q & ARREADY;
  assign rlast_hs   = RVALID & out_ready & RLAST;
  assign outst_full = (outst_q == OW'(MAX_OUTST));

  // Disabled streams load remaining=0, so a non-zero count alone means eligible.
  always_comb begin
    for (int s = 0; s < NUM_STREAMS; s++) begin
      rem_nz[s] = (rem_q[s] != 16'd0);
    end
    req = outst_full ? '0 : rem_nz;
  end

  rr_arbiter #(.N(NUM_STREAMS)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (grant),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cfg_load = 1'b0;
    grant    = 1'b0;
    done_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (stream_en == '0 || bursts == 16'd0) begin
            done_set = 1'b1;
          end else begin
            cfg_load = 1'b1;
            state_d  = ARB;
          end
        end
      end
      ARB: begin
        if (|arb_gnt) begin
          grant   = 1'b1;
          state_d = ADDR;
        end else if (rem_nz == '0) begin
          state_d = DRAIN;
        end
      end
      ADDR: begin
        if (ar_hs) state_d = ARB;
      end
      DRAIN: begin
        if (outst_q == '0) begin
          done_set = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        base_q[s] <= '0;
        rem_q[s]  <= '0;
        iss_q[s]  <= '0;
      end
      cur_q     <= '0;
      outst_q   <= '0;
      araddr_q  <= '0;
      arid_q    <= '0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_set;
      if (cfg_load) begin
        for (int s = 0; s < NUM_STREAMS; s++) begin
          base_q[s] <= base_addr[s*ADDR_W +: ADDR_W];
          rem_q[s]  <= stream_en[s] ? bursts : 16'd0;
          iss_q[s]  <= 16'd0;
        end
      end
      if (grant) begin
        // Address wraps silently modulo 2^ADDR_W.
        araddr_q  <= base_q[arb_idx] + ADDR_W'(iss_q[arb_idx]) * BURST_BYTES;
        arid_q    <= ID_W'(arb_idx);
        arvalid_q <= 1'b1;
        cur_q     <= arb_idx;
      end
      if (ar_hs) begin
        arvalid_q     <= 1'b0;
        rem_q[cur_q]  <= rem_q[cur_q] - 16'd1;
        iss_q[cur_q]  <= iss_q[cur_q] + 16'd1;
      end
      // Simultaneous issue and completion cancel out.
      if (ar_hs && !rlast_hs) begin
        outst_q <= outst_q + OW'(1);
      end else if (!ar_hs && rlast_hs && outst_q != '0) begin
        outst_q <= outst_q - OW'(1);
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign ARADDR  = araddr_q;
  assign ARID    = arid_q;
  assign ARLEN   = 8'(BURST_LEN);
  assign ARVALID = arvalid_q;

  assign out_valid  = RVALID;
  assign out_data   = RDATA;
  assign out_last   = RLAST;
  assign out_stream = RID[SW-1:0];
  assign RREADY     = out_ready;

`ifdef AXI_RD_SCHED_CHECK_EN
  logic [7:0]    beat_q [NUM_STREAMS];
  logic          err_q;
  logic          r_hs;
  logic          id_bad;
  logic          last_exp;
  logic          beat_bad;
  logic [SW-1:0] rsid;

  assign r_hs     = RVALID & out_ready;
  assign id_bad   = (32'(RID) >= 32'(NUM_STREAMS));
  assign rsid     = RID[SW-1:0];
  assign last_exp = (beat_q[rsid] == 8'(BURST_LEN));
  assign beat_bad = r_hs & ((RRESP != OKAY) | id_bad | (!id_bad & (RLAST != last_exp)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
      for (int s = 0; s < NUM_STREAMS; s++) beat_q[s] <= '0;
    end else begin
      if (beat_bad) err_q <= 1'b1;
      // Resynchronise on every RLAST so one bad burst does not poison the next.
      if (r_hs && !id_bad) begin
        beat_q[rsid] <= RLAST ? 8'd0 : beat_q[rsid] + 8'd1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_rsp;
  assign unused_rsp = ^{RRESP, RID};
  assign err        = 1'b0;
`endif

endmodule
